// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions.
// Contents:
//   state_t           - control states of the iterative core (IDLE, RUN, DONE)
//   IV                - standard SHA-256 initial hash value, H0 in the MSBs
//   K[0:63]           - round constants
//   PAD_WORD, PAD_LEN - fixed padding words for a 640-bit header message
//   ch, maj, Sigma0, Sigma1, sigma0, sigma1 - the SHA-256 logical functions
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // A header tail occupies W0..W3. The message is 640 bits long, so the
  // second block carries the '1' pad bit in W4 and the length in W15.
  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] PAD_LEN  = 32'h00000280;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Ports:
//   state_in  [255:0] - working variables a..h, a in the MSBs
//   k         [31:0]  - round constant K[t]
//   w         [31:0]  - schedule word W[t]
//   state_out [255:0] - updated a..h after this round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;
  assign t1 = h + Sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = Sigma0(a) + maj(a, b, c);
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_iter_core.sv
// Folded SHA-256 compression engine, UNROLL rounds per clock.
// Ports:
//   CLK, RST      - rising-edge clock, asynchronous active-low reset
//   flush         - synchronous abort of any job in flight
//   in_valid/in_ready   - job handshake; chain_in, block_in, tag_in and
//                         in_tail_mode are sampled on the accepting edge
//   in_tail_mode  - 1: block_in[127:0] is a header tail, padding is implied
//   chain_in      - H0..H7 (H0 in MSBs), initial a..h and feed-forward addend
//   block_in      - W0..W15 (W0 in MSBs)
//   tag_in        - opaque job tag carried to tag_out
//   out_valid/out_ready - result handshake; digest_out/tag_out held in DONE
//   digest_out    - chain_in + final a..h, word-wise
//   tag_out       - tag of the job on digest_out
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_tail_mode,
  input  logic [255:0]     chain_in,
  input  logic [511:0]     block_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     digest_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int ROUNDS = 64 / UNROLL;
  localparam int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
          UNROLL == 16 || UNROLL == 32 || UNROLL == 64)) begin : g_bad_unroll
      $error("sha256_iter_core: UNROLL must be one of 1,2,4,8,16,32,64");
    end
  endgenerate

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [255:0] chain_q;
  logic [255:0] work;
  logic [TAG_W-1:0] tag_q;
  logic [31:0] win      [0:15];
  logic [31:0] win_next [0:15];
  logic [31:0] load_win [0:15];
  logic [255:0] round_out;
  logic [255:0] digest_next;
  logic accept;
  logic finish_run;

  // Schedule extension: word j of the chain is W[t+j] where t is the round
  // at the head of the window. Entries past 15 are expanded on the fly so
  // this cycle's UNROLL rounds and the next window are both available.
  generate
    for (genvar j = 0; j < 16 + UNROLL; j++) begin : g_ext
      logic [31:0] word;
      if (j < 16) begin : g_direct
        assign word = win[j];
      end else begin : g_expand
        assign word = sigma1(g_ext[j-2].word) + g_ext[j-7].word +
                      sigma0(g_ext[j-15].word) + g_ext[j-16].word;
      end
    end

    for (genvar j = 0; j < 16; j++) begin : g_win_next
      assign win_next[j] = g_ext[j + UNROLL].word;
    end
  endgenerate

  // Round chain: UNROLL rounds back to back, round t = cnt*UNROLL + i.
  generate
    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
      logic [255:0] st_in;
      logic [255:0] st_out;
      logic [5:0]   idx;
      if (i == 0) begin : g_first
        assign st_in = work;
      end else begin : g_next
        assign st_in = g_rnd[i-1].st_out;
      end
      assign idx = 6'(32'(cnt) * UNROLL + i);
      sha256_round u_round (
        .state_in  (st_in),
        .k         (K[idx]),
        .w         (g_ext[i].word),
        .state_out (st_out)
      );
    end
  endgenerate

  assign round_out = g_rnd[UNROLL-1].st_out;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_ff
      assign digest_next[255-32*i -: 32] = chain_q[255-32*i -: 32] +
                                           round_out[255-32*i -: 32];
    end
  endgenerate

  // Initial window: either the full block or the header tail expanded with
  // the fixed pad and length words.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      load_win[j] = block_in[511-32*j -: 32];
    end
    if (in_tail_mode) begin
      for (int j = 0; j < 16; j++) begin
        load_win[j] = 32'h0;
      end
      load_win[0]  = block_in[127:96];
      load_win[1]  = block_in[95:64];
      load_win[2]  = block_in[63:32];
      load_win[3]  = block_in[31:0];
      load_win[4]  = PAD_WORD;
      load_win[15] = PAD_LEN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control: flush overrides everything. DONE with out_ready doubles as an
  // accept slot so consecutive jobs run without an idle bubble.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    finish_run = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept     = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            finish_run = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            in_ready = 1'b1;
            if (in_valid) begin
              accept     = 1'b1;
              state_next = RUN;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign out_valid = (state == DONE);

  // Round counter and result registers; the result holds across flush.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt        <= '0;
      digest_out <= '0;
      tag_out    <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (accept || finish_run) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (finish_run) begin
        digest_out <= digest_next;
        tag_out    <= tag_q;
      end
    end
  end

  // Working variables and schedule window carry no reset; they are always
  // loaded on accept before being used.
  always_ff @(posedge CLK) begin
    if (accept) begin
      chain_q <= chain_in;
      tag_q   <= tag_in;
      work    <= chain_in;
      for (int j = 0; j < 16; j++) begin
        win[j] <= load_win[j];
      end
    end else if (state == RUN) begin
      work <= round_out;
      for (int j = 0; j < 16; j++) begin
        win[j] <= win_next[j];
      end
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Self-checking bench for sha256_iter_core with UNROLL = 1, 4 and 64.
// Expected digests come from known answers and from a plain SHA-256
// compression model written below from the algorithm definition.
module tb_sha256_iter_core;

  localparam logic [255:0] IV_T = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_BLOCK_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLOCK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk, rst_n, flush, in_valid, out_ready, tail_mode;
  logic [255:0] chain;
  logic [511:0] block;
  logic [31:0] tag;
  int sel;

  logic iv1, iv4, iv64, or1, or4, or64;
  logic ir1, ir4, ir64, ov1, ov4, ov64;
  logic [255:0] dg1, dg4, dg64;
  logic [31:0] to1, to4, to64;

  logic cur_ready, cur_valid;
  logic [255:0] cur_digest;
  logic [31:0] cur_tag;

  int n_checks = 0;
  int n_fail = 0;
  logic [255:0] exp_last1;
  logic [31:0] exp_tag_last1;

  // Only the selected core sees in_valid; the others always drain.
  assign iv1  = in_valid && (sel == 0);
  assign iv4  = in_valid && (sel == 1);
  assign iv64 = in_valid && (sel == 2);
  assign or1  = (sel == 0) ? out_ready : 1'b1;
  assign or4  = (sel == 1) ? out_ready : 1'b1;
  assign or64 = (sel == 2) ? out_ready : 1'b1;

  always_comb begin
    cur_ready = ir1; cur_valid = ov1; cur_digest = dg1; cur_tag = to1;
    if (sel == 1) begin
      cur_ready = ir4; cur_valid = ov4; cur_digest = dg4; cur_tag = to4;
    end else if (sel == 2) begin
      cur_ready = ir64; cur_valid = ov64; cur_digest = dg64; cur_tag = to64;
    end
  end

  sha256_iter_core #(.UNROLL(1), .TAG_W(32)) u_core1 (
    .CLK(clk), .RST(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_tail_mode(tail_mode), .chain_in(chain), .block_in(block), .tag_in(tag),
    .out_valid(ov1), .out_ready(or1), .digest_out(dg1), .tag_out(to1));

  sha256_iter_core #(.UNROLL(4), .TAG_W(32)) u_core4 (
    .CLK(clk), .RST(rst_n), .flush(flush), .in_valid(iv4), .in_ready(ir4),
    .in_tail_mode(tail_mode), .chain_in(chain), .block_in(block), .tag_in(tag),
    .out_valid(ov4), .out_ready(or4), .digest_out(dg4), .tag_out(to4));

  sha256_iter_core #(.UNROLL(64), .TAG_W(32)) u_core64 (
    .CLK(clk), .RST(rst_n), .flush(flush), .in_valid(iv64), .in_ready(ir64),
    .in_tail_mode(tail_mode), .chain_in(chain), .block_in(block), .tag_in(tag),
    .out_valid(ov64), .out_ready(or64), .digest_out(dg64), .tag_out(to64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one block: full 64-word schedule,
  // 64 rounds, then feed-forward add.
  function automatic logic [255:0] ref_compress(input logic [255:0] c,
                                                input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = c[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = c[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Latency is the number of rising edges from the accepting edge up to the
  // first edge at which the consumer can take the digest.
  task automatic run_job(input logic [255:0] c, input logic [511:0] b,
                         input logic [31:0] t, input logic m,
                         output logic [255:0] d, output logic [31:0] to,
                         output int lat);
    int waited;
    int n;
    chain = c; block = b; tag = t; tail_mode = m; in_valid = 1'b1;
    #1;
    waited = 0;
    while (!cur_ready && waited < 200) begin
      @(posedge clk); @(negedge clk); #1; waited++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chain = rnd256(); block = rnd512(); tag = $urandom(); tail_mode = $urandom_range(0, 1);
    #1;
    n = 0;
    while (!cur_valid && n < 300) begin
      @(posedge clk); n++; @(negedge clk); #1;
    end
    lat = cur_valid ? n + 1 : -1;
    d = cur_digest;
    to = cur_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tail_mode = 1'b0; chain = '0; block = '0; tag = '0; sel = 0;
    #12;
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", ov1); end
    n_checks++; if (dg1 !== 256'h0) begin n_fail++; $display("[TB] FAIL reset_digest: got %h want 0", dg1); end
    n_checks++; if (to1 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_tag: got %h want 0", to1); end
    n_checks++; if (ov64 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid_u64: got %b want 0", ov64); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({ir1, ir4, ir64} !== 3'b111) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 111", {ir1, ir4, ir64}); end
  endtask

  task automatic test_abc();
    logic [255:0] d; logic [31:0] to; int lat;
    sel = 0;
    run_job(IV_T, ABC_BLOCK, 32'h0000abcd, 1'b0, d, to, lat);
    n_checks++; if (d !== ABC_DIGEST) begin n_fail++; $display("[TB] FAIL abc_digest: got %h want %h", d, ABC_DIGEST); end
    n_checks++; if (d !== ref_compress(IV_T, ABC_BLOCK)) begin n_fail++; $display("[TB] FAIL abc_model: got %h want %h", d, ref_compress(IV_T, ABC_BLOCK)); end
    n_checks++; if (lat !== 65) begin n_fail++; $display("[TB] FAIL abc_latency_u1: got %0d want 65", lat); end
    n_checks++; if (to !== 32'h0000abcd) begin n_fail++; $display("[TB] FAIL abc_tag: got %h want 0000abcd", to); end
  endtask

  task automatic test_empty();
    logic [255:0] d; logic [31:0] to; int lat;
    sel = 2;
    run_job(IV_T, EMPTY_BLOCK, 32'h11111111, 1'b0, d, to, lat);
    n_checks++; if (d !== EMPTY_DIGEST) begin n_fail++; $display("[TB] FAIL empty_digest_u64: got %h want %h", d, EMPTY_DIGEST); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL empty_latency_u64: got %0d want 2", lat); end
    sel = 1;
    run_job(IV_T, EMPTY_BLOCK, 32'h22222222, 1'b0, d, to, lat);
    n_checks++; if (d !== EMPTY_DIGEST) begin n_fail++; $display("[TB] FAIL empty_digest_u4: got %h want %h", d, EMPTY_DIGEST); end
    n_checks++; if (lat !== 17) begin n_fail++; $display("[TB] FAIL empty_latency_u4: got %0d want 17", lat); end
  endtask

  task automatic test_two_block();
    logic [255:0] d1, d2; logic [31:0] to; int lat;
    sel = 1;
    run_job(IV_T, TWO_BLK1, 32'h1, 1'b0, d1, to, lat);
    n_checks++; if (d1 !== ref_compress(IV_T, TWO_BLK1)) begin n_fail++; $display("[TB] FAIL two_block_mid: got %h want %h", d1, ref_compress(IV_T, TWO_BLK1)); end
    run_job(d1, TWO_BLK2, 32'h2, 1'b0, d2, to, lat);
    n_checks++; if (d2 !== TWO_BLOCK_DIGEST) begin n_fail++; $display("[TB] FAIL two_block_final: got %h want %h", d2, TWO_BLOCK_DIGEST); end
  endtask

  task automatic test_random_jobs();
    logic [255:0] c, d, e; logic [511:0] b; logic [31:0] t, to; int lat, lat_exp;
    logic m;
    for (int k = 0; k < 6; k++) begin
      sel = k % 3;
      m = (k % 2) == 0;
      c = rnd256(); b = rnd512(); t = $urandom();
      if (m) e = ref_compress(c, {b[127:0], 32'h80000000, 320'h0, 32'h00000280});
      else   e = ref_compress(c, b);
      lat_exp = 64 / ((sel == 0) ? 1 : (sel == 1) ? 4 : 64) + 1;
      run_job(c, b, t, m, d, to, lat);
      n_checks++; if (d !== e) begin n_fail++; $display("[TB] FAIL random_digest[%0d] mode=%b: got %h want %h", k, m, d, e); end
      n_checks++; if (to !== t) begin n_fail++; $display("[TB] FAIL random_tag[%0d]: got %h want %h", k, to, t); end
      n_checks++; if (lat !== lat_exp) begin n_fail++; $display("[TB] FAIL random_latency[%0d]: got %0d want %0d", k, lat, lat_exp); end
    end
  endtask

  // Hold the result with out_ready low, then drain and accept in one edge.
  task automatic test_back_to_back();
    logic [255:0] ca, cb, d, ea, eb; logic [511:0] ba, bb; logic [31:0] ta, tb, to;
    int lat, n;
    sel = 0;
    ca = rnd256(); ba = rnd512(); ta = $urandom();
    cb = rnd256(); bb = rnd512(); tb = $urandom();
    ea = ref_compress(ca, ba);
    eb = ref_compress(cb, {bb[127:0], 32'h80000000, 320'h0, 32'h00000280});
    out_ready = 1'b0;
    run_job(ca, ba, ta, 1'b0, d, to, lat);
    n_checks++; if (d !== ea) begin n_fail++; $display("[TB] FAIL bp_digest_a: got %h want %h", d, ea); end
    chain = cb; block = bb; tag = tb; tail_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks++; if (ov1 !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", i, ov1); end
      n_checks++; if (dg1 !== ea) begin n_fail++; $display("[TB] FAIL bp_digest_hold[%0d]: got %h want %h", i, dg1, ea); end
      n_checks++; if (to1 !== ta) begin n_fail++; $display("[TB] FAIL bp_tag_hold[%0d]: got %h want %h", i, to1, ta); end
      n_checks++; if (ir1 !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, ir1); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready: got %b want 1", ir1); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; chain = rnd256(); block = rnd512(); tag = $urandom();
    #1;
    n = 0;
    while (!ov1 && n < 300) begin
      @(posedge clk); n++; @(negedge clk); #1;
    end
    lat = ov1 ? n + 1 : -1;
    n_checks++; if (lat !== 65) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want 65", lat); end
    n_checks++; if (dg1 !== eb) begin n_fail++; $display("[TB] FAIL b2b_digest: got %h want %h", dg1, eb); end
    n_checks++; if (to1 !== tb) begin n_fail++; $display("[TB] FAIL b2b_tag: got %h want %h", to1, tb); end
    exp_last1 = eb;
    exp_tag_last1 = tb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [255:0] d; logic [31:0] to; int lat;
    logic saw_valid;
    sel = 0;
    chain = rnd256(); block = rnd512(); tag = $urandom(); tail_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    n_checks++; if (ir1 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_in_ready_during: got %b want 0", ir1); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_out_valid: got %b want 0", ov1); end
    n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready_after: got %b want 1", ir1); end
    n_checks++; if (dg1 !== exp_last1) begin n_fail++; $display("[TB] FAIL flush_digest_kept: got %h want %h", dg1, exp_last1); end
    n_checks++; if (to1 !== exp_tag_last1) begin n_fail++; $display("[TB] FAIL flush_tag_kept: got %h want %h", to1, exp_tag_last1); end
    saw_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ov1) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_result: got %b want 0", saw_valid); end
    run_job(IV_T, ABC_BLOCK, 32'h0f0f0f0f, 1'b0, d, to, lat);
    n_checks++; if (d !== ABC_DIGEST) begin n_fail++; $display("[TB] FAIL flush_then_abc: got %h want %h", d, ABC_DIGEST); end
  endtask

  task automatic test_reset_mid_run();
    sel = 0;
    chain = rnd256(); block = rnd512(); tag = $urandom(); tail_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_valid: got %b want 0", ov1); end
    n_checks++; if (dg1 !== 256'h0) begin n_fail++; $display("[TB] FAIL async_reset_digest: got %h want 0", dg1); end
    n_checks++; if (to1 !== 32'h0) begin n_fail++; $display("[TB] FAIL async_reset_tag: got %h want 0", to1); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", ir1); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_random_jobs();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
